// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// wishbone_interface
//   Minimal Wishbone classic bundle used by the instruction fetch unit.
//   Only the read path is modelled: the fetch unit never writes.
//
//   cyc       master -> slave   bus cycle in progress
//   stb       master -> slave   strobe, one-cycle pulse per request
//   adr[31:0] master -> slave   word address of the request
//   dat_miso  slave  -> master  read data, valid while ack is high
//   ack       slave  -> master  transfer acknowledge
// ---------------------------------------------------------------------------
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [31:0] dat_miso;
  logic        ack;

  modport master (output cyc, stb, adr, input  dat_miso, ack);
  modport slave  (input  cyc, stb, adr, output dat_miso, ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction prefetcher. Issues one Wishbone read at a time,
//   stores {pc, word} pairs in a small FIFO and presents the head to the
//   decoder with a valid/ready handshake. A redirect pulse flushes the FIFO
//   and restarts fetching at a new word-aligned address; a bus read that is
//   already in flight is allowed to finish but its data is dropped.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch buffer entries (power of two, >= 2)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   fetch_en     allows new bus requests to be issued
//   redirect     one-cycle flush + refetch pulse
//   redirect_pc  new fetch address, bits [1:0] ignored
//   port_m       Wishbone master (cyc, stb, adr out; dat_miso, ack in)
//   instr_valid  FIFO head holds a valid instruction
//   instr        head instruction word
//   instr_pc     address the head word was fetched from
//   instr_ready  downstream consumes head when instr_valid && instr_ready
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  wishbone_interface.master        port_m,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      adr_q;
  logic             discard_q;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           hold_q;

  // -------------------------------------------------------------------------
  // Control decodes
  // -------------------------------------------------------------------------
  logic        cyc;
  logic        stb;
  logic        has_space;
  logic        issue;
  logic        ack_done;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  entry_t      head;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Only one request is ever outstanding and requests only leave IDLE, so a
  // free slot seen at issue time is still free when the ack returns (pops can
  // only add room). This is what keeps push from ever overflowing.
  assign has_space = (count_q < CNT_W'(FIFO_DEPTH));
  assign issue     = (state_q == IDLE) && fetch_en && has_space && !redirect;
  assign ack_done  = (state_q == WAIT) && port_m.ack;

  // A redirect on the ack cycle kills that word as well as any word whose
  // request was outstanding when an earlier redirect arrived.
  assign push      = ack_done && !discard_q && !redirect;

  // Flush beats consume: a pop in the redirect cycle is ignored.
  assign pop       = instr_valid && instr_ready && !redirect;

  // -------------------------------------------------------------------------
  // Bus FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all
      // flops sample pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    cyc     = 1'b0;
    stb     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = REQ;
      end
      REQ: begin
        cyc     = 1'b1;
        stb     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        cyc = 1'b1;
        if (port_m.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cyc/stb decode straight from the state register, so an asynchronous
  // reset drops them in the same cycle without waiting for a clock edge.
  assign port_m.cyc = cyc;
  assign port_m.stb = stb;
  assign port_m.adr = adr_q;

  // -------------------------------------------------------------------------
  // Fetch address, request address and discard flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      adr_q      <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      // The bus address is captured at issue and held through WAIT, so a
      // redirect mid-transaction moves fetch_pc without disturbing the bus.
      if (issue) begin
        adr_q <= fetch_pc_q;
      end

      if (redirect) begin
        fetch_pc_q <= redirect_target;
      end else if (push) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end

      // The ack closes the transaction the flag refers to. A redirect on
      // that same cycle needs no flag because the word is already dropped.
      if (ack_done) begin
        discard_q <= 1'b0;
      end else if (redirect && (state_q != IDLE)) begin
        discard_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only observable once count
    // covers it, and that requires a prior write.
    if (push) begin
      mem[wr_ptr_q] <= '{pc: fetch_pc_q, word: port_m.dat_miso};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '{pc: 32'h0000_0000, word: NOP_INSTR};
    end else begin
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        // Depth is a power of two, so pointers wrap naturally.
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
          count_q <= count_q - 1'b1;
        end
      end

      // Remember whatever head is on display so the outputs stay stable
      // (and never show uninitialised storage) once the FIFO drains.
      if (instr_valid) begin
        hold_q <= head;
      end
    end
  end

  assign head        = mem[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? head.word : hold_q.word;
  assign instr_pc    = instr_valid ? head.pc   : hold_q.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Scoreboard bench for instr_fetch_unit. Stimulus pushes the expected bus
//   addresses and expected {pc, instr} pairs into queues; a monitor pops and
//   compares whenever the DUT raises stb or hands over an instruction.
//   A second instance with RESET_PC = 0xFFFFFFFC covers address wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        fetch_en2 = 1'b0;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  wishbone_interface wb ();
  wishbone_interface wb2 ();

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_adr_q [$];
  logic [63:0] exp_instr_q [$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .port_m      (wb),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en2),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .port_m      (wb2),
    .instr_valid (instr_valid2),
    .instr       (instr2),
    .instr_pc    (instr_pc2),
    .instr_ready (1'b1)
  );

  // Memory image seen by both slaves.
  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hDEAD_0000);
  endfunction

  // Two-cycle registered slaves: stb sampled, then ack two edges later.
  logic        s1 = 1'b0, ack_r = 1'b0, force_ack = 1'b0;
  logic [31:0] dat = 32'h0;
  logic        s1b = 1'b0, ack_rb = 1'b0;
  logic [31:0] datb = 32'h0;

  always @(posedge clk) begin
    s1     <= wb.cyc && wb.stb && !rst;
    ack_r  <= s1 && wb.cyc && !rst;
    if (s1) dat <= slave_word(wb.adr);
    s1b    <= wb2.cyc && wb2.stb && !rst;
    ack_rb <= s1b && wb2.cyc && !rst;
    if (s1b) datb <= slave_word(wb2.adr);
  end

  assign wb.ack       = ack_r | force_ack;
  assign wb.dat_miso  = force_ack ? 32'hBAD0_BAD0 : dat;
  assign wb2.ack      = ack_rb;
  assign wb2.dat_miso = datb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every request and every consumed instruction.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && wb.cyc && wb.stb) begin
      if (exp_adr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_adr: unexpected request adr=%h, none expected", wb.adr);
      end else begin
        check("bus_adr", wb.adr, exp_adr_q.pop_front());
      end
    end
    if (!rst && !redirect && instr_valid && instr_ready) begin
      if (exp_instr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL instr_pop: unexpected instr=%h pc=%h, none expected", instr, instr_pc);
      end else begin
        e = exp_instr_q.pop_front();
        check("instr_pc", instr_pc, e[63:32]);
        check("instr", instr, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
  endtask

  // Waits for n stb pulses; optionally stops further issue right after.
  task automatic wait_stb(input int n, input bit drop);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (wb.cyc && wb.stb) seen++;
    end
    if (seen < n) begin
      tests++;
      fails++;
      $display("FAIL wait_stb: saw %0d requests, needed %0d", seen, n);
    end
    if (drop) fetch_en = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while (i < 300 && (exp_adr_q.size() != 0 || exp_instr_q.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    check("drain_adr", exp_adr_q.size(), 0);
    check("drain_instr", exp_instr_q.size(), 0);
    exp_adr_q.delete();
    exp_instr_q.delete();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int          cnt;
    logic [31:0] seen_adr [$];
    logic [63:0] seen_ins [$];

    // ---- Reset state -------------------------------------------------------
    tick();
    tick();
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_cyc", wb.cyc, 0);
    check("rst_stb", wb.stb, 0);
    check("rst_adr", wb.adr, 32'h0);
    check("rst_adr_wrap", wb2.adr, 32'hFFFF_FFFC);

    // ---- First fetch after reset ------------------------------------------
    exp_adr_q = '{32'h0, 32'h4};
    exp_instr_q = '{{32'h0, 32'h0050_0093}, {32'h4, 32'hDEAD_0004}};
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    rst = 1'b0;
    wait_stb(2, 1'b1);
    wait_drain();
    check("idle_adr_held", wb.adr, 32'h4);
    check("idle_cyc", wb.cyc, 0);

    // ---- FIFO full: exactly four requests until a pop ----------------------
    enter_reset();
    instr_ready = 1'b0;
    fetch_en = 1'b1;
    exp_adr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_instr_q = '{{32'h0, 32'h0050_0093}, {32'h4, 32'hDEAD_0004},
                    {32'h8, 32'hDEAD_0008}, {32'hC, 32'hDEAD_000C},
                    {32'h10, 32'hDEAD_0010}};
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb.cyc && wb.stb) cnt++;
    end
    check("full_stb_count", cnt, 4);
    check("full_valid", instr_valid, 1);
    check("full_head_pc", instr_pc, 32'h0);
    exp_adr_q.push_back(32'h10);
    tick();
    instr_ready = 1'b1;
    wait_stb(1, 1'b1);
    wait_drain();

    // ---- Redirect during WAIT, with coincident pop -------------------------
    enter_reset();
    instr_ready = 1'b0;
    fetch_en = 1'b1;
    exp_adr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_instr_q = '{{32'h100, 32'hDEAD_0100}};
    rst = 1'b0;
    wait_stb(3, 1'b0);
    tick();
    check("pre_redirect_valid", instr_valid, 1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("flush_valid", instr_valid, 0);
    check("flush_hold_pc", instr_pc, 32'h0);
    check("flush_hold_instr", instr, 32'h0050_0093);
    check("flush_cyc_kept", wb.cyc, 1);
    check("flush_adr_kept", wb.adr, 32'h8);
    wait_stb(1, 1'b1);
    wait_drain();

    // ---- Redirect coincident with ack -------------------------------------
    enter_reset();
    instr_ready = 1'b1;
    fetch_en = 1'b1;
    exp_adr_q = '{32'h0, 32'h4, 32'h8, 32'h200};
    exp_instr_q = '{{32'h0, 32'h0050_0093}, {32'h4, 32'hDEAD_0004},
                    {32'h200, 32'hDEAD_0200}};
    rst = 1'b0;
    wait_stb(3, 1'b0);
    tick();
    tick();
    check("ack_coincident", wb.ack, 1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("ack_redirect_valid", instr_valid, 0);
    wait_stb(1, 1'b1);
    wait_drain();

    // ---- Address wrap from RESET_PC = 0xFFFFFFFC ---------------------------
    enter_reset();
    fetch_en2 = 1'b1;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (wb2.cyc && wb2.stb) begin
        seen_adr.push_back(wb2.adr);
        if (seen_adr.size() == 2) fetch_en2 = 1'b0;
      end
      if (instr_valid2) seen_ins.push_back({instr_pc2, instr2});
    end
    check("wrap_req_count", seen_adr.size(), 2);
    check("wrap_instr_count", seen_ins.size(), 2);
    if (seen_adr.size() >= 2) begin
      check("wrap_adr0", seen_adr[0], 32'hFFFF_FFFC);
      check("wrap_adr1", seen_adr[1], 32'h0);
    end
    if (seen_ins.size() >= 2) begin
      check("wrap_pc0", seen_ins[0][63:32], 32'hFFFF_FFFC);
      check("wrap_instr0", seen_ins[0][31:0], 32'h2152_FFFC);
      check("wrap_pc1", seen_ins[1][63:32], 32'h0);
      check("wrap_instr1", seen_ins[1][31:0], 32'h0050_0093);
    end

    // ---- Reset mid-transaction and stray ack ------------------------------
    enter_reset();
    instr_ready = 1'b1;
    fetch_en = 1'b1;
    exp_adr_q = '{32'h0};
    rst = 1'b0;
    wait_stb(1, 1'b1);
    tick();
    check("mid_cyc_before", wb.cyc, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", wb.cyc, 0);
    check("mid_rst_stb", wb.stb, 0);
    check("mid_rst_valid", instr_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (4) tick();
    check("stray_ack_valid", instr_valid, 0);
    check("stray_ack_cyc", wb.cyc, 0);
    check("stray_ack_instr", instr, 32'h0000_0013);
    check("stray_adr_q", exp_adr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  permits new bus requests when high.
REQ-006 redirect  input  1  one-cycle pulse, branch/jump: flush and refetch.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
REQ-008 port_m  wishbone_interface.master  -  uses cyc, stb, adr (out, 32), dat_miso (in, 32), ack (in, 1).
REQ-009 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-010 instr  output  32  head instruction word.
REQ-011 instr_pc  output  32  address the head word was fetched from.
REQ-012 instr_ready  input  1  downstream consumes head when instr_valid && instr_ready.

Function
REQ-013 FSM states IDLE, REQ, WAIT; exactly one bus request outstanding at any time.
REQ-014 IDLE->REQ when fetch_en && (fifo_count + 1 <= FIFO_DEPTH) && !redirect; otherwise stay IDLE.
REQ-015 REQ: cyc=1, stb=1, adr=fetch_pc for exactly one cycle; then unconditionally ->WAIT.
REQ-016 WAIT: cyc=1, stb=0, adr held; stays until ack sampled high, then ->IDLE.
REQ-017 stb is a single-cycle pulse per request; cyc stays high from REQ until the ack cycle inclusive, low the cycle after.
REQ-018 No assumption on ack latency; with a 2-cycle-registered slave, stb-to-ack is 2 edges, 4 cycles per fetch.
REQ-019 On ack in WAIT without pending discard: push {fetch_pc, dat_miso} into FIFO; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0).
REQ-020 FIFO space is reserved at issue: a request issues only if the response is guaranteed a free slot; push never overflows.
REQ-021 Push and pop in the same cycle are both honoured; count unchanged.
REQ-022 Pop when empty has no effect; instr_valid=0 while empty.
REQ-023 redirect (any state): FIFO flushed same edge (count=0, instr_valid low next cycle); fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-024 redirect while in REQ or WAIT: set discard flag; bus transaction completes normally; its ack data is dropped, fetch_pc not incremented; flag clears on that ack.
REQ-025 redirect coincident with ack: data dropped, fetch_pc = redirect target, FIFO flushed.
REQ-026 redirect coincident with pop: flush wins; pop ignored.
REQ-027 fetch_en low does not abort an outstanding request; only blocks new issues.
REQ-028 instr/instr_pc hold last head values when FIFO empty; X never propagated.

Reset
REQ-029 On rst: state=IDLE, cyc=0, stb=0, adr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, discard=0.
REQ-030 On rst: instr_valid=0, instr=32'h00000013, instr_pc=32'h00000000.
REQ-031 rst mid-transaction: cyc/stb drop immediately (async); late ack after release is ignored (state IDLE ignores ack).
REQ-032 First REQ after reset no earlier than first rising edge after rst deasserts with fetch_en=1.

Verification
REQ-033 Reset release, fetch_en=1, instr_ready=1, slave returns 32'h00500093 at 0x0 -> instr_valid with instr=32'h00500093, instr_pc=0x0; next adr=0x4.
REQ-034 instr_ready=0, FIFO_DEPTH=4 -> exactly 4 requests (0x0..0xC) issued, no fifth stb until one pop.
REQ-035 redirect to 0x00000103 during WAIT for 0x8 -> 0x8 data discarded, FIFO empty, next adr=0x100, next instr_pc=0x100.
REQ-036 redirect with ack same cycle -> acked word never appears at instr; next adr=redirect target.
REQ-037 RESET_PC=32'hFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000.
REQ-038 rst asserted while cyc=1 -> cyc=0, stb=0 same cycle; instr_valid=0; subsequent stray ack produces no push.
